// File: rtl/pc_stack_if.sv
// Command/status bundle between the instruction decoder and pc_stack.
// The decoder drives the command side (master); pc_stack answers on the status side (slave).
interface pc_stack_if #(
  parameter int DWIDTH      = 16,
  parameter int OWIDTH      = 8,
  parameter int STACK_DEPTH = 4
);
  localparam int SPW = $clog2(STACK_DEPTH + 1);

  // Command handshake: en_in is a valid strobe with no ready; every cycle with
  // en_in=1 is one accepted command, and its result shows on pc_out/sp_out next cycle.
  logic              en_in;
  logic [2:0]        pc_ctrl;
  logic [OWIDTH-1:0] offset_addr;
  logic [DWIDTH-1:0] jump_addr;
  logic              clr_err;

  logic [DWIDTH-1:0] pc_out;
  logic [SPW-1:0]    sp_out;
  logic              stack_ovf;
  logic              stack_unf;
  logic              trap_out;

  modport master (
    output en_in, pc_ctrl, offset_addr, jump_addr, clr_err,
    input  pc_out, sp_out, stack_ovf, stack_unf, trap_out
  );

  modport slave (
    input  en_in, pc_ctrl, offset_addr, jump_addr, clr_err,
    output pc_out, sp_out, stack_ovf, stack_unf, trap_out
  );
endinterface

// File: rtl/pc_stack.sv
// Program counter with relative branch, jump, call/return stack, reload and sticky stack errors.
// Optional macro PC_TRAP_EN redirects overflowing CALL / underflowing RET to TRAP_VEC with a trap pulse.
module pc_stack #(
  parameter int              DWIDTH      = 16,
  parameter int              OWIDTH      = 8,
  parameter int              STACK_DEPTH = 4,
  parameter logic [DWIDTH-1:0] RST_VEC   = '0,
  parameter logic [DWIDTH-1:0] TRAP_VEC  = 16'h00F0
) (
  input logic        clk,
  input logic        rst_n,
  pc_stack_if.slave  bus
);

  localparam int SPW = $clog2(STACK_DEPTH + 1);
  localparam int IW  = $clog2(STACK_DEPTH);

`ifdef PC_TRAP_EN
  localparam bit TRAP_EN = 1'b1;
`else
  localparam bit TRAP_EN = 1'b0;
`endif

  typedef enum logic [2:0] {
    CMD_HOLD   = 3'b000,
    CMD_INC    = 3'b001,
    CMD_BRANCH = 3'b010,
    CMD_JUMP   = 3'b011,
    CMD_CALL   = 3'b100,
    CMD_RET    = 3'b101,
    CMD_RELOAD = 3'b110,
    CMD_RSVD   = 3'b111
  } cmd_e;

  logic [DWIDTH-1:0] pc_q, pc_d;
  logic [SPW-1:0]    sp_q, sp_d;
  logic              ovf_q, unf_q, trap_q;
  logic [DWIDTH-1:0] stack_mem [STACK_DEPTH];

  cmd_e              cmd;
  logic              full, empty;
  logic              push;
  logic              ovf_set, unf_set;
  logic [DWIDTH-1:0] ret_addr;
  logic [DWIDTH-1:0] branch_tgt;
  logic [DWIDTH-1:0] top_entry;
  logic [IW-1:0]     top_idx;

  assign cmd        = cmd_e'(bus.pc_ctrl);
  assign full       = (sp_q == SPW'(STACK_DEPTH));
  assign empty      = (sp_q == '0);
  assign ret_addr   = pc_q + DWIDTH'(1);
  assign branch_tgt = pc_q + DWIDTH'($signed(bus.offset_addr));
  // Top index is only meaningful when the stack is non-empty; pin it to 0 otherwise.
  assign top_idx    = empty ? '0 : IW'(sp_q - SPW'(1));
  assign top_entry  = stack_mem[top_idx];

  always_comb begin
    pc_d    = pc_q;
    sp_d    = sp_q;
    push    = 1'b0;
    ovf_set = 1'b0;
    unf_set = 1'b0;
    if (bus.en_in) begin
      case (cmd)
        CMD_INC:    pc_d = ret_addr;
        CMD_BRANCH: pc_d = branch_tgt;
        CMD_JUMP:   pc_d = bus.jump_addr;
        CMD_CALL: begin
          if (full) begin
            ovf_set = 1'b1;
            if (TRAP_EN) pc_d = TRAP_VEC;
          end else begin
            push = 1'b1;
            sp_d = sp_q + SPW'(1);
            pc_d = bus.jump_addr;
          end
        end
        CMD_RET: begin
          if (empty) begin
            unf_set = 1'b1;
            if (TRAP_EN) pc_d = TRAP_VEC;
          end else begin
            sp_d = sp_q - SPW'(1);
            pc_d = top_entry;
          end
        end
        CMD_RELOAD: begin
          pc_d = RST_VEC;
          sp_d = '0;
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc_q   <= RST_VEC;
      sp_q   <= '0;
      ovf_q  <= 1'b0;
      unf_q  <= 1'b0;
      trap_q <= 1'b0;
    end else begin
      pc_q   <= pc_d;
      sp_q   <= sp_d;
      // A new error in the same cycle as clr_err leaves the flag set.
      ovf_q  <= ovf_set | (ovf_q & ~bus.clr_err);
      unf_q  <= unf_set | (unf_q & ~bus.clr_err);
      trap_q <= TRAP_EN & (ovf_set | unf_set);
    end
  end

  // Entry contents carry no reset; sp alone decides what is valid.
  always_ff @(posedge clk) begin
    if (rst_n && push) stack_mem[IW'(sp_q)] <= ret_addr;
  end

  assign bus.pc_out    = pc_q;
  assign bus.sp_out    = sp_q;
  assign bus.stack_ovf = ovf_q;
  assign bus.stack_unf = unf_q;
  assign bus.trap_out  = TRAP_EN ? trap_q : 1'b0;

endmodule

// File: tb/tb_pc_stack.sv
// Randomised and directed bench for pc_stack against a queue-based reference model.
module tb_pc_stack;

  localparam int DW = 16;
  localparam int OW = 8;
  localparam int SD = 4;

  logic clk;
  logic rst_n;

  pc_stack_if #(.DWIDTH(DW), .OWIDTH(OW), .STACK_DEPTH(SD)) bus ();

  pc_stack #(.DWIDTH(DW), .OWIDTH(OW), .STACK_DEPTH(SD)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  // reference model
  logic [DW-1:0] m_pc;
  logic [DW-1:0] m_stk[$];
  logic          m_ovf, m_unf, m_trap;
  bit            trap_build;

  int checks = 0;
  int errors = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic check_all(input string tag);
    check({tag, ".pc"},   32'(bus.pc_out),    32'(m_pc));
    check({tag, ".sp"},   32'(bus.sp_out),    32'(m_stk.size()));
    check({tag, ".ovf"},  32'(bus.stack_ovf), 32'(m_ovf));
    check({tag, ".unf"},  32'(bus.stack_unf), 32'(m_unf));
    check({tag, ".trap"}, 32'(bus.trap_out),  32'(m_trap));
  endtask

  task automatic model_reset();
    m_pc = '0;
    m_stk.delete();
    m_ovf = 1'b0;
    m_unf = 1'b0;
    m_trap = 1'b0;
  endtask

  task automatic model_step(input logic en, input logic [2:0] ctrl, input logic [OW-1:0] off,
                            input logic [DW-1:0] ja, input logic clr);
    bit ovf_ev = 0;
    bit unf_ev = 0;
    int signed soff;
    soff = int'($signed(off));
    if (en) begin
      case (ctrl)
        3'd1: m_pc = DW'(int'(m_pc) + 1);
        3'd2: m_pc = DW'(int'(m_pc) + soff);
        3'd3: m_pc = ja;
        3'd4: if (m_stk.size() < SD) begin
                m_stk.push_back(DW'(int'(m_pc) + 1));
                m_pc = ja;
              end else ovf_ev = 1;
        3'd5: if (m_stk.size() > 0) m_pc = m_stk.pop_back();
              else unf_ev = 1;
        3'd6: begin m_pc = '0; m_stk.delete(); end
        default: ;
      endcase
    end
    if (trap_build && (ovf_ev || unf_ev)) m_pc = 16'h00F0;
    m_trap = trap_build && (ovf_ev || unf_ev);
    m_ovf = ovf_ev ? 1'b1 : (clr ? 1'b0 : m_ovf);
    m_unf = unf_ev ? 1'b1 : (clr ? 1'b0 : m_unf);
  endtask

  // driver tasks
  task automatic step(input string tag, input logic en, input logic [2:0] ctrl,
                      input logic [OW-1:0] off, input logic [DW-1:0] ja, input logic clr);
    bus.en_in       = en;
    bus.pc_ctrl     = ctrl;
    bus.offset_addr = off;
    bus.jump_addr   = ja;
    bus.clr_err     = clr;
    @(posedge clk);
    model_step(en, ctrl, off, ja, clr);
    #1;
    check_all(tag);
  endtask

  task automatic pulse_reset(input string tag);
    #2;
    rst_n = 1'b0;
    model_reset();
    #1;
    check_all(tag);
    rst_n = 1'b1;
  endtask

  initial begin
`ifdef PC_TRAP_EN
    trap_build = 1;
`else
    trap_build = 0;
`endif
    rst_n = 1'b0;
    bus.en_in = 0; bus.pc_ctrl = 0; bus.offset_addr = 0; bus.jump_addr = 0; bus.clr_err = 0;
    model_reset();
    #2;
    check_all("reset");
    rst_n = 1'b1;

    // increment and enable gating
    step("inc1", 1, 3'd1, 0, 0, 0);
    step("inc2", 1, 3'd1, 0, 0, 0);
    step("inc3", 1, 3'd1, 0, 0, 0);
    check("inc_pc3", 32'(bus.pc_out), 32'd3);
    step("noen1", 0, 3'd1, 0, 0, 0);
    step("noen2", 0, 3'd1, 0, 0, 0);
    check("noen_pc", 32'(bus.pc_out), 32'd3);

    // jump, negative branch, wrap
    step("jump10", 1, 3'd3, 0, 16'h0010, 0);
    step("brFE",   1, 3'd2, 8'hFE, 0, 0);
    check("brFE_pc", 32'(bus.pc_out), 32'h000E);
    step("jmpFFFF", 1, 3'd3, 0, 16'hFFFF, 0);
    step("incwrap", 1, 3'd1, 0, 0, 0);
    check("wrap_pc", 32'(bus.pc_out), 32'h0000);
    step("brunder", 1, 3'd2, 8'h80, 0, 0);
    step("callFFFF_pre", 1, 3'd3, 0, 16'hFFFF, 0);
    step("callwrap", 1, 3'd4, 0, 16'h0300, 0);
    step("retwrap", 1, 3'd5, 0, 0, 0);
    check("retwrap_pc", 32'(bus.pc_out), 32'h0000);

    // nested call / return
    step("j20",   1, 3'd3, 0, 16'h0020, 0);
    step("call1", 1, 3'd4, 0, 16'h0100, 0);
    step("call2", 1, 3'd4, 0, 16'h0200, 0);
    step("ret1",  1, 3'd5, 0, 0, 0);
    check("ret1_pc", 32'(bus.pc_out), 32'h0101);
    step("ret2",  1, 3'd5, 0, 0, 0);
    check("ret2_pc", 32'(bus.pc_out), 32'h0021);

    // overflow then clear
    for (int i = 1; i <= 5; i++) step("ovfcall", 1, 3'd4, 0, DW'(i * 16'h0100), 0);
    check("ovf_flag", 32'(bus.stack_ovf), 32'd1);
    check("ovf_sp", 32'(bus.sp_out), 32'd4);
    step("clr", 0, 3'd0, 0, 0, 1);
    check("ovf_clr", 32'(bus.stack_ovf), 32'd0);

    // underflow, with set-wins on simultaneous clear
    step("reload", 1, 3'd6, 0, 0, 0);
    step("unf", 1, 3'd5, 0, 0, 0);
    check("unf_flag", 32'(bus.stack_unf), 32'd1);
    step("unf_trap_drop", 1, 3'd0, 0, 0, 0);
    step("unf_setwins", 1, 3'd5, 0, 0, 1);
    step("unf_clr", 1, 3'd0, 0, 0, 1);

    // reset mid-sequence and reload with a partly full stack
    step("rc1", 1, 3'd4, 0, 16'h0400, 0);
    step("rc2", 1, 3'd4, 0, 16'h0500, 0);
    pulse_reset("midreset");
    for (int i = 0; i < 3; i++) step("pre_reload", 1, 3'd4, 0, DW'(16'h0600 + i), 0);
    step("reload3", 1, 3'd6, 0, 0, 0);
    check("reload_sp", 32'(bus.sp_out), 32'd0);

    // randomised command stream
    for (int n = 0; n < 1500; n++) begin
      logic [2:0] c;
      c = 3'($urandom_range(0, 7));
      if ($urandom_range(0, 199) == 0) pulse_reset("rnd_reset");
      else step("rnd", ($urandom_range(0, 9) != 0), c, OW'($urandom),
                DW'($urandom), ($urandom_range(0, 9) == 0));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
